// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and constants for the RV32M unit.
// Divide support is built only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

   localparam int XLEN_DEF = 32;
   localparam int CNT_W    = $clog2(XLEN_DEF);

   localparam logic [2:0] F3_MUL  = 3'b000;
   localparam logic [2:0] F3_MULH = 3'b001;
   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   function automatic logic op_div(input logic [2:0] f3);
      return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
   endfunction

   function automatic logic op_rem(input logic [2:0] f3);
      return f3 inside {F3_REM, F3_REMU};
   endfunction

   // 010/011 run as MUL, so everything except DIVU/REMU is signed
   function automatic logic op_signed(input logic [2:0] f3);
      return !(f3 inside {F3_DIVU, F3_REMU});
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: restoring-divide remainder/quotient registers.
// Only instantiated when MULDIV_DIV_EN is defined.
import muldiv_pkg::*;

module muldiv_div_core #(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quo_nx,
   output logic [XLEN-1:0] rem_nx
);

   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dvs;
   logic [XLEN:0]   part;
   logic            fits;

   // part < 2*dvs, so the difference always fits XLEN bits
   assign part   = {rem, quo[XLEN-1]};
   assign fits   = part >= {1'b0, dvs};
   assign rem_nx = fits ? part[XLEN-1:0] - dvs : part[XLEN-1:0];
   assign quo_nx = {quo[XLEN-2:0], fits};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         quo <= '0;
         rem <= '0;
         dvs <= '0;
      end else if (load) begin
         quo <= dividend;
         rem <= '0;
         dvs <= divisor;
      end else if (step) begin
         quo <= quo_nx;
         rem <= rem_nx;
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide in EX, stalls via busy_o.
// Define MULDIV_DIV_EN to build the divide datapath.
import muldiv_pkg::*;

module ex_muldiv #(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [9:0]      funct_i,
   input  logic [XLEN-1:0] RS1data_i,
   input  logic [XLEN-1:0] RS2data_i,
   input  logic [4:0]      RDaddr_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      RDaddr_o
);

   localparam int CW = $clog2(XLEN);

   state_t            state;
   logic [CW-1:0]     cnt;
   logic [2:0]        f3_q;
   logic              neg_q;
   logic [XLEN-1:0]   mcand_q;
   logic [2*XLEN-1:0] acc;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   res_q;

   logic [2:0]      f3;
   logic            unused_funct7;
   logic            a_neg;
   logic            b_neg;
   logic            acc_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            special;
   logic [XLEN-1:0] sp_res;

   assign f3            = funct_i[2:0];
   assign unused_funct7 = ^funct_i[9:3];
   assign a_neg   = op_signed(f3) & RS1data_i[XLEN-1];
   assign b_neg   = op_signed(f3) & RS2data_i[XLEN-1];
   assign a_mag   = a_neg ? -RS1data_i : RS1data_i;
   assign b_mag   = b_neg ? -RS2data_i : RS2data_i;
   assign acc_neg = op_rem(f3) ? a_neg : a_neg ^ b_neg;

`ifdef MULDIV_DIV_EN
   logic b_zero;
   logic ovf;

   assign b_zero  = RS2data_i == '0;
   assign ovf     = op_signed(f3) & (RS1data_i == INT_MIN)
                  & (RS2data_i == ALL_ONES);
   assign special = op_div(f3) & (b_zero | ovf);
   assign sp_res  = b_zero ? (op_rem(f3) ? RS1data_i : ALL_ONES)
                           : (op_rem(f3) ? '0 : INT_MIN);
`else
   assign special = op_div(f3);
   assign sp_res  = '0;
`endif

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] acc_nx;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   mul_res;
   logic [XLEN-1:0]   fin_res;

   assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]}
                  + {1'b0, mcand_q & {XLEN{acc[0]}}};
   assign acc_nx  = {mul_sum, acc[XLEN-1:1]};
   assign prod    = neg_q ? -acc_nx : acc_nx;
   assign mul_res = (f3_q == F3_MULH) ? prod[2*XLEN-1:XLEN]
                                      : prod[XLEN-1:0];

`ifdef MULDIV_DIV_EN
   logic [XLEN-1:0] quo_nx;
   logic [XLEN-1:0] rem_nx;
   logic [XLEN-1:0] div_res;

   muldiv_div_core #(
      .XLEN(XLEN)
   ) u_div (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load     (start_i & (state != S_BUSY)),
      .step     (state == S_BUSY),
      .dividend (a_mag),
      .divisor  (b_mag),
      .quo_nx   (quo_nx),
      .rem_nx   (rem_nx)
   );

   assign div_res = op_rem(f3_q) ? (neg_q ? -rem_nx : rem_nx)
                                 : (neg_q ? -quo_nx : quo_nx);
   assign fin_res = op_div(f3_q) ? div_res : mul_res;
`else
   assign fin_res = mul_res;
`endif

   assign busy_o   = rst_i & ((state == S_BUSY) | start_i);
   assign done_o   = state == S_DONE;
   assign result_o = res_q;
   assign RDaddr_o = rd_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state   <= S_IDLE;
         cnt     <= '0;
         f3_q    <= '0;
         neg_q   <= 1'b0;
         mcand_q <= '0;
         acc     <= '0;
         rd_q    <= '0;
         res_q   <= '0;
      end else begin
         unique case (state)
            S_BUSY: begin
               acc <= acc_nx;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(XLEN - 1)) begin
                  state <= S_DONE;
                  res_q <= fin_res;
               end
            end
            default: begin
               res_q <= '0;
               state <= S_IDLE;
               if (start_i) begin
                  f3_q    <= f3;
                  neg_q   <= acc_neg;
                  mcand_q <= a_mag;
                  acc     <= {{XLEN{1'b0}}, b_mag};
                  rd_q    <= RDaddr_i;
                  cnt     <= '0;
                  if (special) begin
                     state <= S_DONE;
                     res_q <= sp_res;
                  end else begin
                     state <= S_BUSY;
                  end
               end
            end
         endcase
      end
   end

endmodule
